// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: power-up sequencer for the main PLL. The block runs on the free-running
// reference clock CLKI. It pulses PLL_RST and waits for a synchronised LOCK to stay high for a
// qualified time before it releases SYS_RSTN. It handles lock loss, retries a lock timeout a bounded
// number of times, and parks the PLL in a sticky FAULT state when every retry has failed.
module pll_lock_supervisor #(
    parameter  int unsigned RST_PULSE_CYCLES    = 16,
    parameter  int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter  int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter  int unsigned MAX_RETRIES         = 3,
    parameter  int unsigned LOSS_CNT_W          = 8,
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                  CLKI,
    input  logic                  RSTN,
    input  logic                  LOCK,
    input  logic                  FORCE_RELOCK,
    input  logic                  CLEAR_FAULT,
    output logic                  PLL_RST,
    output logic                  SYS_RSTN,
    output logic                  READY,
    output logic                  FAULT,
    output logic [RETRY_W-1:0]    RETRY_COUNT,
    output logic [LOSS_CNT_W-1:0] LOSS_COUNT
);

    // One counter serves every timed state, so it is sized for the longest interval.
    localparam int unsigned MAX_A      = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                         RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [RETRY_W-1:0]    retry_q,    retry_d;
    logic [LOSS_CNT_W-1:0] loss_q,     loss_d;
    logic                  lock_meta_q, lock_meta_d;
    logic                  lock_s_q,   lock_s_d;
    logic                  pll_rst_q,  pll_rst_d;
    logic                  sys_rstn_q, sys_rstn_d;
    logic                  ready_q,    ready_d;
    logic                  fault_q,    fault_d;

    // Next-state, counter and registered-output logic. The FSM sees only the synchronised lock_s_q.
    always_comb begin
        // NOTE: every signal gets a default value before the case. An assignment that is missing on
        // some path would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        lock_meta_d = LOCK;
        lock_s_d    = lock_meta_q;

        case (state_q)
            S_RESET_PLL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                // Lock wins over a timeout that falls in the same cycle.
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                // A lock loss takes precedence over a relock request in the same cycle.
                if (!lock_s_q) begin
                    state_d = S_RESET_PLL;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end else if (FORCE_RELOCK) begin
                    state_d = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                if (CLEAR_FAULT) begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // Every transition restarts the shared interval counter.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // The outputs are decoded from the next state. They then change on the same edge as the
        // state itself, and no combinational path reaches a pin.
        pll_rst_d  = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rstn_d = (state_d == S_RUN);
        ready_d    = (state_d == S_RUN);
        fault_d    = (state_d == S_FAULT);
    end

    // State, counters, lock synchroniser and output registers, with a synchronous reset.
    always_ff @(posedge CLKI) begin
        // NOTE: sequential state uses non-blocking assignments only. All flops then update together
        // and simulation matches the synthesised hardware.
        if (!RSTN) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rstn_q  <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            pll_rst_q   <= pll_rst_d;
            sys_rstn_q  <= sys_rstn_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign PLL_RST     = pll_rst_q;
    assign SYS_RSTN    = sys_rstn_q;
    assign READY       = ready_q;
    assign FAULT       = fault_q;
    assign RETRY_COUNT = retry_q;
    assign LOSS_COUNT  = loss_q;

endmodule
